// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: pipelined two-level carry-lookahead adder/subtractor.
// Ports: clock, reset (sync, active-high); in_valid/in_ready with op1,
//   op2, sub, cin; out_valid/out_ready with sum, crout, ovf, zero.
//   Latency is WIDTH/BLOCK cycles after the operand register.
module cla_addsub_pipe #(
    parameter int WIDTH = 64,
    parameter int BLOCK = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             crout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = WIDTH / BLOCK;
    localparam int NG     = BLOCK / 4;

    if ((WIDTH % BLOCK) != 0 || (BLOCK % 4) != 0) begin : g_bad_param
        $fatal(1, "cla_addsub_pipe: WIDTH/BLOCK not legal");
    end

    // Carry into position n as a flat sum of products (no ripple).
    function automatic logic la_carry(
        input logic [BLOCK-1:0] p,
        input logic [BLOCK-1:0] g,
        input logic             ci,
        input int               n
    );
        logic c;
        logic t;
        c = ci;
        for (int i = 0; i < BLOCK; i++) begin
            if (i < n) c = c & p[i];
        end
        for (int j = 0; j < BLOCK; j++) begin
            if (j < n) begin
                t = g[j];
                for (int m = 0; m < BLOCK; m++) begin
                    if (m > j && m < n) t = t & p[m];
                end
                c = c | t;
            end
        end
        return c;
    endfunction

    // One slice: 4-bit groups give P/G, a second level gives group
    // carries. Returns {carry into MSB, carry out, slice sum}.
    function automatic logic [BLOCK+1:0] slice_add(
        input logic [BLOCK-1:0] a,
        input logic [BLOCK-1:0] b,
        input logic             ci
    );
        logic [BLOCK-1:0] p, g, c;
        logic [BLOCK-1:0] gp, gg, pl, gl;
        logic             gcin;
        logic             cout;
        p  = a ^ b;
        g  = a & b;
        gp = '0;
        gg = '0;
        c  = '0;
        for (int k = 0; k < NG; k++) begin
            pl      = '0;
            gl      = '0;
            pl[3:0] = p[4*k +: 4];
            gl[3:0] = g[4*k +: 4];
            gp[k]   = &pl[3:0];
            gg[k]   = la_carry(pl, gl, 1'b0, 4);
        end
        for (int k = 0; k < NG; k++) begin
            gcin    = la_carry(gp, gg, ci, k);
            pl      = '0;
            gl      = '0;
            pl[3:0] = p[4*k +: 4];
            gl[3:0] = g[4*k +: 4];
            for (int i = 0; i < 4; i++) begin
                c[4*k+i] = la_carry(pl, gl, gcin, i);
            end
        end
        cout = la_carry(gp, gg, ci, NG);
        return {c[BLOCK-1], cout, p ^ c};
    endfunction

    logic             advance;
    logic             v_q [0:STAGES];
    logic             c_q [0:STAGES];
    logic [WIDTH-1:0] a_q [0:STAGES-1];
    logic [WIDTH-1:0] b_q [0:STAGES-1];
    logic [WIDTH-1:0] r_q [1:STAGES];
    logic             ovf_q;
    logic             zero_q;

    logic [BLOCK+1:0] sl   [1:STAGES];
    logic [WIDTH-1:0] nres [1:STAGES];

    assign advance = !v_q[STAGES] || out_ready;

    always_comb begin
        for (int s = 1; s <= STAGES; s++) begin
            sl[s] = slice_add(a_q[s-1][(s-1)*BLOCK +: BLOCK],
                              b_q[s-1][(s-1)*BLOCK +: BLOCK],
                              c_q[s-1]);
        end
        nres[1]            = '0;
        nres[1][BLOCK-1:0] = sl[1][BLOCK-1:0];
        for (int s = 2; s <= STAGES; s++) begin
            nres[s] = r_q[s-1];
            nres[s][(s-1)*BLOCK +: BLOCK] = sl[s][BLOCK-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s <= STAGES; s++) begin
                v_q[s] <= 1'b0;
                c_q[s] <= 1'b0;
            end
            for (int s = 0; s < STAGES; s++) begin
                a_q[s] <= '0;
                b_q[s] <= '0;
            end
            for (int s = 1; s <= STAGES; s++) begin
                r_q[s] <= '0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            v_q[0] <= in_valid;
            a_q[0] <= op1;
            b_q[0] <= sub ? ~op2 : op2;
            c_q[0] <= sub | cin;
            for (int s = 1; s < STAGES; s++) begin
                v_q[s] <= v_q[s-1];
                a_q[s] <= a_q[s-1];
                b_q[s] <= b_q[s-1];
                c_q[s] <= sl[s][BLOCK];
                r_q[s] <= nres[s];
            end
            v_q[STAGES] <= v_q[STAGES-1];
            // Result registers keep the last real result across bubbles.
            if (v_q[STAGES-1]) begin
                r_q[STAGES] <= nres[STAGES];
                c_q[STAGES] <= sl[STAGES][BLOCK];
                ovf_q  <= sl[STAGES][BLOCK+1] ^ sl[STAGES][BLOCK];
                zero_q <= ~|nres[STAGES];
            end
        end
    end

    assign in_ready  = advance;
    assign out_valid = v_q[STAGES];
    assign sum       = r_q[STAGES];
    assign crout     = c_q[STAGES];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb_cla_addsub_pipe: self-checking bench for cla_addsub_pipe.
// Drives a 64/16 and a 32/8 instance against an arithmetic model.
module tb_cla_addsub_pipe;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        iv = 1'b0, ir, ordy = 1'b1, ov;
    logic [63:0] a = '0, b = '0, s;
    logic        sb = 1'b0, ci = 1'b0, co, of, z;

    logic        iv2 = 1'b0, ir2, ordy2 = 1'b1, ov2;
    logic [31:0] a2 = '0, b2 = '0, s2;
    logic        sb2 = 1'b0, ci2 = 1'b0, co2, of2, z2;

    int total = 0;
    int bad   = 0;

    cla_addsub_pipe #(.WIDTH(64), .BLOCK(16)) dut64 (
        .clock(clock), .reset(reset),
        .in_valid(iv), .in_ready(ir),
        .op1(a), .op2(b), .sub(sb), .cin(ci),
        .out_valid(ov), .out_ready(ordy),
        .sum(s), .crout(co), .ovf(of), .zero(z)
    );

    cla_addsub_pipe #(.WIDTH(32), .BLOCK(8)) dut32 (
        .clock(clock), .reset(reset),
        .in_valid(iv2), .in_ready(ir2),
        .op1(a2), .op2(b2), .sub(sb2), .cin(ci2),
        .out_valid(ov2), .out_ready(ordy2),
        .sum(s2), .crout(co2), .ovf(of2), .zero(z2)
    );

    // Model: {zero, ovf, crout, sum} from plain integer arithmetic.
    function automatic logic [66:0] ref_op(
        input int          w,
        input logic [63:0] x,
        input logic [63:0] y,
        input logic        op_sub,
        input logic        c_in
    );
        logic [64:0] full;
        logic [63:0] mask, r;
        logic        c, o, sx, sy, sr;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        x = x & mask;
        y = y & mask;
        if (op_sub) begin
            full = {1'b0, x} - {1'b0, y};
            c    = (x >= y);
        end else begin
            full = {1'b0, x} + {1'b0, y} + {64'd0, c_in};
            c    = full[w];
        end
        r  = full[63:0] & mask;
        sx = x[w-1];
        sy = y[w-1];
        sr = r[w-1];
        if (op_sub) o = (sx != sy) && (sr != sx);
        else        o = (sx == sy) && (sr != sx);
        return {(r == 64'd0), o, c, r};
    endfunction

    // Issue one op into an empty pipe and wait for its result.
    task automatic issue_wait(
        input  bit          narrow,
        input  logic [63:0] x,
        input  logic [63:0] y,
        input  logic        op_sub,
        input  logic        c_in,
        output logic [63:0] rs,
        output logic        rc,
        output logic        ro,
        output logic        rz,
        output int          lat
    );
        if (narrow) begin
            a2 = x[31:0]; b2 = y[31:0];
            sb2 = op_sub; ci2 = c_in;
            iv2 = 1'b1; ordy2 = 1'b1;
        end else begin
            a = x; b = y; sb = op_sub; ci = c_in;
            iv = 1'b1; ordy = 1'b1;
        end
        @(posedge clock); #1;
        iv  = 1'b0;
        iv2 = 1'b0;
        lat = -1;
        rs = '0; rc = 1'b0; ro = 1'b0; rz = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock); #1;
            if (narrow ? ov2 : ov) begin
                lat = k;
                rs = narrow ? {32'd0, s2} : s;
                rc = narrow ? co2 : co;
                ro = narrow ? of2 : of;
                rz = narrow ? z2 : z;
                break;
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        total++;
        if ({ov, s, co, of, z} !== 68'd0) begin
            bad++;
            $display("FAIL reset_out: got v=%b s=%h c=%b o=%b z=%b want 0",
                     ov, s, co, of, z);
        end
        total++;
        if (ir !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", ir);
        end
        total++;
        if (ov2 !== 1'b0 || s2 !== 32'd0 || ir2 !== 1'b1) begin
            bad++;
            $display("FAIL reset_narrow: got v=%b s=%h r=%b want 0,0,1",
                     ov2, s2, ir2);
        end
    endtask

    task automatic test_carry_wrap();
        logic [63:0] rs;
        logic rc, ro, rz;
        int lat;
        issue_wait(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0,
                   rs, rc, ro, rz, lat);
        total++;
        if (lat !== 4) begin
            bad++;
            $display("FAIL wrap_latency: got %0d want 4", lat);
        end
        total++;
        if ({rs, rc, ro, rz} !== {64'd0, 1'b1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL wrap_result: got s=%h c=%b o=%b z=%b want 0,1,0,1",
                     rs, rc, ro, rz);
        end
    endtask

    task automatic test_overflow();
        logic [63:0] rs;
        logic rc, ro, rz;
        int lat;
        issue_wait(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0,
                   rs, rc, ro, rz, lat);
        total++;
        if (lat !== 4 || {rs, rc, ro, rz} !==
            {64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL ovf_add: got lat=%0d s=%h c=%b o=%b z=%b want 4,8000..,0,1,0",
                     lat, rs, rc, ro, rz);
        end
    endtask

    task automatic test_sub();
        logic [63:0] rs;
        logic rc, ro, rz;
        int lat;
        issue_wait(0, 64'd5, 64'd7, 1, 1, rs, rc, ro, rz, lat);
        total++;
        if (lat !== 4 || {rs, rc, ro, rz} !==
            {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL sub_5_7: got lat=%0d s=%h c=%b o=%b z=%b want 4,..FE,0,0,0",
                     lat, rs, rc, ro, rz);
        end
    endtask

    task automatic test_stream();
        logic [66:0] q[$];
        logic [66:0] e;
        logic [63:0] x, y, held;
        logic        hc, ho, hz, stall;
        int issued, got, cyc;
        issued = 0; got = 0; cyc = 0; stall = 1'b0;
        held = '0; hc = 1'b0; ho = 1'b0; hz = 1'b0;
        while (got < 16 && cyc < 400) begin
            if (stall) begin
                total++;
                if (ov !== 1'b1 || s !== held || co !== hc ||
                    of !== ho || z !== hz) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b s=%h want 1 s=%h",
                             ov, s, held);
                end
            end
            ordy = 1'($urandom_range(0, 1));
            if (issued < 16) begin
                x = {$urandom, $urandom};
                y = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) x = '1;
                if ($urandom_range(0, 3) == 0) y = 64'd1;
                a = x; b = y;
                sb = 1'($urandom_range(0, 1));
                ci = 1'($urandom_range(0, 1));
                iv = 1'b1;
            end else begin
                iv = 1'b0;
            end
            #1;
            total++;
            if (ir !== (!ov || ordy)) begin
                bad++;
                $display("FAIL in_ready: got %b want %b", ir, !ov || ordy);
            end
            if (ov && ordy) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL stream_extra: got s=%h want none", s);
                end else begin
                    e = q.pop_front();
                    if ({z, of, co, s} !== e) begin
                        bad++;
                        $display("FAIL stream_result: got z=%b o=%b c=%b s=%h want %h",
                                 z, of, co, s, e);
                    end
                end
                got++;
            end
            if (iv && ir) begin
                q.push_back(ref_op(64, a, b, sb, ci));
                issued++;
            end
            stall = ov && !ordy;
            held = s; hc = co; ho = of; hz = z;
            @(posedge clock); #1;
            cyc++;
        end
        iv = 1'b0;
        ordy = 1'b1;
        total++;
        if (got != 16 || q.size() != 0) begin
            bad++;
            $display("FAIL stream_count: got %0d left %0d want 16 left 0",
                     got, q.size());
        end
        repeat (6) @(posedge clock);
        #1;
    endtask

    task automatic test_reset_flush();
        logic [63:0] rs;
        logic rc, ro, rz;
        int lat;
        ordy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 64'(i + 1); b = 64'd3; sb = 1'b0; ci = 1'b0;
            iv = 1'b1;
            @(posedge clock); #1;
        end
        iv = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (ov !== 1'b0) begin
                bad++;
                $display("FAIL flush_valid: got %b want 0 at cycle %0d", ov, k);
            end
            @(posedge clock); #1;
        end
        issue_wait(0, 64'h10, 64'h20, 0, 0, rs, rc, ro, rz, lat);
        total++;
        if (lat !== 4 || rs !== 64'h30) begin
            bad++;
            $display("FAIL flush_next: got lat=%0d s=%h want 4 s=30", lat, rs);
        end
    endtask

    task automatic test_narrow();
        logic [63:0] rs;
        logic rc, ro, rz;
        int lat;
        issue_wait(1, 64'h00FF_FFFF, 64'h1, 0, 0, rs, rc, ro, rz, lat);
        total++;
        if (lat !== 4 || rs !== 64'h0100_0000 || rc !== 1'b0) begin
            bad++;
            $display("FAIL narrow_carry: got lat=%0d s=%h c=%b want 4,01000000,0",
                     lat, rs, rc);
        end
        issue_wait(1, 64'hFFFF_FFFF, 64'h0, 0, 1, rs, rc, ro, rz, lat);
        total++;
        if (lat !== 4 || rs !== 64'd0 || rc !== 1'b1 || rz !== 1'b1) begin
            bad++;
            $display("FAIL narrow_cin: got lat=%0d s=%h c=%b z=%b want 4,0,1,1",
                     lat, rs, rc, rz);
        end
        for (int i = 0; i < 4; i++) begin
            logic [63:0] x, y;
            logic [66:0] e;
            logic op_sub, c_in;
            x = 64'($urandom);
            y = 64'($urandom);
            op_sub = 1'($urandom_range(0, 1));
            c_in = 1'($urandom_range(0, 1));
            e = ref_op(32, x, y, op_sub, c_in);
            issue_wait(1, x, y, op_sub, c_in, rs, rc, ro, rz, lat);
            total++;
            if (lat !== 4 || {rz, ro, rc, rs} !== e) begin
                bad++;
                $display("FAIL narrow_rand: got lat=%0d z=%b o=%b c=%b s=%h want %h",
                         lat, rz, ro, rc, rs, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_carry_wrap();
        test_overflow();
        test_sub();
        test_stream();
        test_reset_flush();
        test_narrow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined two-level carry-lookahead adder/subtractor.
- Successor to the fixed 64-bit registered CLA: generic width, configurable pipeline depth, add/sub mode, status flags, and valid/ready flow control with backpressure.
- Sits between operand-issue logic and result consumers in the datapath.
- Accepts one operation per cycle, at a fixed latency.

Parameters:
- WIDTH, 64, operand/result width in bits; must be a multiple of BLOCK.
- BLOCK, 16, bits resolved per pipeline stage; must be a multiple of 4.
- STAGES (derived, localparam), WIDTH/BLOCK, number of carry stages and the latency in cycles.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operands and mode valid
- in_ready  out  1  block can accept operands this cycle
- op1  in  WIDTH  first operand
- op2  in  WIDTH  second operand
- sub  in  1  0: op1+op2+cin; 1: op1-op2 (computed as op1+~op2+1, cin ignored)
- cin  in  1  carry-in, add mode only
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result, modulo 2^WIDTH
- crout  out  1  carry out of MSB (sub mode: 1 = no borrow)
- ovf  out  1  two's-complement overflow = carry into MSB XOR carry out of MSB
- zero  out  1  sum == 0

Behaviour:
- One clock (clock). Reset is synchronous and active-high (reset).
- Reset:
  - all stage valid bits cleared; all data/carry registers cleared.
  - out_valid=0, sum=0, crout=0, ovf=0, zero=0.
  - in_ready=1 in the first cycle after reset deasserts.
- Elaboration:
  - WIDTH % BLOCK != 0 or BLOCK % 4 != 0 is a fatal elaboration error.
- Flow control:
  - advance = !out_valid || out_ready; in_ready = advance (combinational).
  - All pipeline registers, including the valid bits, load only when advance=1. Otherwise every register holds.
  - Transfer in: in_valid && in_ready at an edge. Transfer out: out_valid && out_ready at an edge.
  - in_valid=0 while advancing inserts a bubble: stage valid bit 0, data don't-care.
- Pipeline:
  - Stage 0 registers op1, ~op2-if-sub, effective carry-in (sub ? 1 : cin) and valid.
  - Stage s (1..STAGES) computes slice [s*BLOCK-1:(s-1)*BLOCK] from the stage s-1 carry, registers it, and forwards the unresolved upper operand bits and carry. Upper operand bits are not re-read from the inputs.
  - Stage STAGES drives sum/crout/ovf/zero/out_valid directly from registers.
- Latency and throughput:
  - Operation accepted at edge T appears with out_valid=1 after edge T+STAGES, provided no stall intervenes. Each stalled cycle adds one cycle.
  - Throughput is 1 op/cycle while out_ready=1.
- Slice logic:
  - Within a slice, 4-bit CLA groups produce group P/G.
  - A second-level lookahead produces group carries; there is no ripple across groups.
  - Carry between slices is registered only.
- Flags:
  - ovf uses the MSB-slice internal carry.
  - zero is computed from the final registered sum bits in the last stage, registered together with sum.
- Outputs:
  - sum/flags remain stable while out_valid=1 and out_ready=0.
  - When out_valid=0 they are undefined to the consumer; the implementation keeps the last value.
- Ordering: strict FIFO order. No drop or duplication under any out_ready pattern.
- Reset mid-operation: all in-flight ops are discarded, with no output for them. The first op accepted after reset has normal latency.
- Simultaneous in/out transfer on one edge: both occur and the pipeline shifts by one.

Test Plan:
- WIDTH=64, BLOCK=16, op1=FFFF_FFFF_FFFF_FFFF, op2=1, cin=0, sub=0 -> 4 cycles later sum=0, crout=1, ovf=0, zero=1, out_valid=1.
- op1=7FFF_FFFF_FFFF_FFFF, op2=1, sub=0 -> sum=8000_0000_0000_0000, crout=0, ovf=1, zero=0. Also op1=0x5, op2=0x7, sub=1, cin=1 -> sum=FFFF_FFFF_FFFF_FFFE, crout=0, ovf=0.
- Stream 16 random ops back-to-back, out_ready random 50% -> results match the reference model in order, count=16, and sum holds stable during every stall cycle.
- Issue 3 ops, assert reset for 1 cycle at the edge after the 3rd accept -> out_valid stays 0, and there is no output for those ops. A new op 0x10+0x20 yields 0x30 after 4 cycles.
- WIDTH=32, BLOCK=8: 0x00FF_FFFF + 0x1 -> 0x0100_0000 after 4 cycles (carry crosses 3 stage boundaries). 0xFFFF_FFFF + 0 with cin=1 -> sum=0, crout=1.
